// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//   Control and sequencing for a FIFO built from DEPTH resettable 8-bit
//   enable registers and an external read multiplexer. This block keeps the
//   head/tail pointers and the occupancy count. It drives one-hot write
//   enables into the register array and the read-mux select. It also produces
//   full/empty status and the per-request ack/error flags.
//
// Parameters
//   DEPTH      number of register entries (power of two, 2..256)
//   AW         pointer width, log2(DEPTH)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   wr_en        write request this cycle
//   rd_en        read request this cycle
//   reg_we       one-hot write enable to register entry i (combinational)
//   rd_sel       read-mux select (registered; holds when no read accepted)
//   full         count == DEPTH
//   empty        count == 0
//   wr_ack       previous-cycle write accepted (registered)
//   wr_err       previous-cycle write rejected because full (registered)
//   rd_ack       previous-cycle read accepted; mux data valid now (registered)
//   rd_err       previous-cycle read rejected because empty (registered)
//   data_count   current occupancy, 0..DEPTH
//   almost_full  count >= DEPTH-1   (only with FIFO_CTRL_ALMOST_EN defined)
//   almost_empty count <= 1         (only with FIFO_CTRL_ALMOST_EN defined)
//
// Build option
//   FIFO_CTRL_ALMOST_EN : when defined, adds the almost_full/almost_empty ports.
// -----------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            rd_en,
    output logic [DEPTH-1:0] reg_we,
    output logic [AW-1:0]   rd_sel,
    output logic            full,
    output logic            empty,
    output logic            wr_ack,
    output logic            wr_err,
    output logic            rd_ack,
    output logic            rd_err,
`ifdef FIFO_CTRL_ALMOST_EN
    output logic            almost_full,
    output logic            almost_empty,
`endif
    output logic [AW:0]     data_count
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_sel_q, rd_sel_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_err_q, rd_err_d;

    logic run;
    logic wacc;
    logic racc;

    localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);

    assign full  = (count_q == COUNT_FULL);
    assign empty = (count_q == '0);

    // Requests are only honoured in RUN; reset is also folded in so reg_we
    // stays quiet during the reset cycle itself, whatever state we were in.
    assign run  = (state_q == ST_RUN) && !reset;
    assign wacc = run && wr_en && !full;
    assign racc = run && rd_en && !empty;

    // One-hot write-enable decode of the tail pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign reg_we[gi] = wacc && (tail_q == AW'(gi));
        end
    endgenerate

    // Next-state / datapath update.
    always_comb begin
        state_d  = ST_RUN;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        rd_sel_d = rd_sel_q;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;

        if (wacc) begin
            tail_d = tail_q + 1'b1;     // wraps naturally modulo 2^AW
        end
        if (racc) begin
            rd_sel_d = head_q;
            head_d   = head_q + 1'b1;
        end

        case ({wacc, racc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (run) begin
            wr_ack_d = wacc;
            wr_err_d = wr_en && full;
            rd_ack_d = racc;
            rd_err_d = rd_en && empty;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rd_sel_q <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            rd_sel_q <= rd_sel_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign rd_sel     = rd_sel_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;
    assign data_count = count_q;

`ifdef FIFO_CTRL_ALMOST_EN
    assign almost_full  = (count_q >= COUNT_FULL - 1'b1);
    assign almost_empty = (count_q <= (AW+1)'(1));
`endif

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control and sequencing block for a FIFO built from an array of DEPTH 8-bit resettable enable registers plus an external read multiplexer.
- Owns the head/tail pointers and the occupancy count.
- Drives one-hot write enables into the register array and the read-mux select.
- Generates full/empty status and per-request ack/error handshake flags for the FIFO top level.

Parameters:
DEPTH, 8, number of register entries; power of two, 2..256
AW, 3, pointer width; equals log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  write request for the current cycle
rd_en  input  1  read request for the current cycle
reg_we  output  DEPTH  one-hot write enable to register entry i; combinational
rd_sel  output  AW  read-mux select; registered
full  output  1  count == DEPTH
empty  output  1  count == 0
wr_ack  output  1  previous-cycle write accepted; registered
wr_err  output  1  previous-cycle write rejected (full); registered
rd_ack  output  1  previous-cycle read accepted; rd data valid this cycle; registered
rd_err  output  1  previous-cycle read rejected (empty); registered
data_count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (clk edge with reset=1):
  - head, tail, count, rd_sel = 0.
  - All ack/err flags = 0; empty = 1; full = 0.
  - FSM enters INIT.
- reg_we is all-zero while reset is high.
- FSM states:
  - INIT: one cycle after reset release. All requests are ignored; no flags set; reg_we = 0. Always goes to RUN.
  - RUN: normal operation; stays in RUN until reset.
- Accept terms (combinational, RUN only):
  - wacc = wr_en & ~full.
  - racc = rd_en & ~empty.
- Write path:
  - reg_we[tail] = wacc; all other bits 0.
  - Register captures d_in on the same clk edge.
  - On that edge, tail <= tail+1, wrapping DEPTH-1 -> 0 (modulo 2^AW).
- Read path:
  - On racc: rd_sel <= head and head <= head+1 (wrap as for tail).
  - Read data appears on the mux output in the following cycle, aligned with rd_ack=1.
  - rd_sel holds its value when no read is accepted.
- Count update:
  - wacc only: +1.
  - racc only: -1.
  - Both, or neither: unchanged.
  - full and empty decode combinationally from the registered count.
- Simultaneous wr_en & rd_en:
  - Not empty and not full: both accepted; count unchanged; wr_ack = rd_ack = 1 next cycle.
  - Empty: write accepted, read rejected; next cycle wr_ack = 1, rd_err = 1; count -> 1.
  - Full: read accepted, write rejected; next cycle rd_ack = 1, wr_err = 1; count -> DEPTH-1. A write is never accepted while full, even with a same-cycle read.
- Flags:
  - Each flag is registered every cycle; set for exactly one cycle per request.
  - wr_ack / wr_err are mutually exclusive; rd_ack / rd_err are mutually exclusive.
  - All four are 0 in cycles with no corresponding request, and in the cycle after INIT.
- Rejected requests leave pointers, count and registers untouched.
- Reset mid-operation: takes effect on the next edge regardless of pending requests. Stored register contents are not cleared by this block; the FIFO reads as empty.

Optional Feature:
- Macro: FIFO_CTRL_ALMOST_EN.
- Defined: adds outputs almost_full (count >= DEPTH-1) and almost_empty (count <= 1), both 1-bit and combinational from count. Reset values: almost_full = 0, almost_empty = 1.
- Undefined: these ports do not exist; all other behaviour is identical.

Test Plan:
- Reset, release, wr_en=1 during the INIT cycle -> no reg_we pulse, wr_ack=0, data_count=0, empty=1.
- 8 consecutive writes from empty -> reg_we = 0x01, 0x02, ..., 0x80 in successive cycles; wr_ack=1 each following cycle; then full=1, data_count=8.
- 9th write while full -> reg_we=0, wr_err=1 next cycle, count stays 8; then 8 reads -> rd_sel = 0..7 each with rd_ack, then empty=1.
- Read while empty -> rd_err=1 next cycle, rd_sel unchanged, data_count=0.
- Fill to 3, then wr_en=rd_en=1 for 10 cycles -> count stays 3; tail and head wrap 7 -> 0; no err flags.
- wr_en=rd_en=1 while empty -> wr_ack=1 and rd_err=1; count=1. Same stimulus while full -> rd_ack=1 and wr_err=1; count=7.
